membus_arbiter: RTL and testbench

Memory-bus arbiter and responder for the VRAM side of the design. It accepts requests from the host register-bus port and two layer-renderer bus-master ports, grants one per cycle, and drives the shared main RAM / character ROM bus. It returns `ack` and read data to the winning master with fixed one-cycle latency. It replaces the inline combinational arbitration in the top level so a second layer renderer can share memory bandwidth.

---
 rtl/membus_arbiter_if.sv | 44 ++++
 rtl/membus_arbiter.sv | 108 ++++++++++
 tb/tb_membus_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/membus_arbiter_if.sv
// Memory-bus arbiter port bundle: host register-bus port, two layer read ports,
// shared RAM/ROM bus. master = requesters plus memories, slave = the arbiter.
interface membus_arbiter_if #(
  parameter int ADDR_WIDTH = 18
);
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [7:0]            host_wrdata;
  logic                  host_write;
  logic                  host_strobe;
  logic                  host_ack;
  logic [7:0]            host_rddata;

  logic [ADDR_WIDTH-1:0] l1_addr;
  logic [ADDR_WIDTH-1:0] l2_addr;
  logic                  l1_strobe;
  logic                  l2_strobe;
  logic                  l1_ack;
  logic                  l2_ack;
  logic [31:0]           l_rddata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wrdata;
  logic [3:0]            mem_bytesel;
  logic                  mem_write;
  logic                  mem_strobe;
  logic [31:0]           ram_rddata;
  logic [31:0]           rom_rddata;

  modport master (
    output host_addr, host_wrdata, host_write, host_strobe,
    output l1_addr, l2_addr, l1_strobe, l2_strobe,
    output ram_rddata, rom_rddata,
    input  host_ack, host_rddata, l1_ack, l2_ack, l_rddata,
    input  mem_addr, mem_wrdata, mem_bytesel, mem_write, mem_strobe
  );

  modport slave (
    input  host_addr, host_wrdata, host_write, host_strobe,
    input  l1_addr, l2_addr, l1_strobe, l2_strobe,
    input  ram_rddata, rom_rddata,
    output host_ack, host_rddata, l1_ack, l2_ack, l_rddata,
    output mem_addr, mem_wrdata, mem_bytesel, mem_write, mem_strobe
  );
endinterface

// File: rtl/membus_arbiter.sv
// VRAM memory-bus arbiter: host beats layers, one grant per cycle, ack + data one cycle later.
// MEMBUS_ROUND_ROBIN_EN: layers alternate on contention; otherwise fixed L1 > L2.
module membus_arbiter #(
  parameter int         ADDR_WIDTH = 18,
  parameter logic [5:0] ROM_BASE   = 6'b10_0000
) (
  input logic             clk,
  input logic             rst,
  membus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_HOST, OWN_L1, OWN_L2} owner_t;

  owner_t                grant;
  owner_t                owner_r;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic                  ram_sel;
  logic                  rom_sel;
  logic                  ram_sel_r;
  logic                  rom_sel_r;
  logic [1:0]            lane_r;
  logic [31:0]           rd_word;
  logic                  l2_first;

`ifdef MEMBUS_ROUND_ROBIN_EN
  logic last_l2_r;

  // Pointer remembers the last layer served; host grants leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_l2_r <= 1'b1;
    end else if (grant == OWN_L1) begin
      last_l2_r <= 1'b0;
    end else if (grant == OWN_L2) begin
      last_l2_r <= 1'b1;
    end
  end

  assign l2_first = !last_l2_r;
`else
  assign l2_first = 1'b0;
`endif

  always_comb begin
    grant    = OWN_NONE;
    gnt_addr = '0;
    if (rst) begin
      grant = OWN_NONE;
    end else if (bus.host_strobe) begin
      grant = OWN_HOST;
    end else if (bus.l1_strobe && bus.l2_strobe) begin
      grant = l2_first ? OWN_L2 : OWN_L1;
    end else if (bus.l1_strobe) begin
      grant = OWN_L1;
    end else if (bus.l2_strobe) begin
      grant = OWN_L2;
    end

    case (grant)
      OWN_HOST: gnt_addr = bus.host_addr;
      OWN_L1:   gnt_addr = bus.l1_addr;
      OWN_L2:   gnt_addr = bus.l2_addr;
      default:  gnt_addr = '0;
    endcase
  end

  assign ram_sel = !gnt_addr[ADDR_WIDTH-1];
  assign rom_sel = (gnt_addr[ADDR_WIDTH-1 -: 6] == ROM_BASE);

  assign bus.mem_addr    = gnt_addr;
  assign bus.mem_strobe  = (grant != OWN_NONE);
  assign bus.mem_write   = (grant == OWN_HOST) && bus.host_write;
  assign bus.mem_wrdata  = rst ? 32'd0 : {4{bus.host_wrdata}};
  assign bus.mem_bytesel = rst ? 4'd0 : (4'b0001 << gnt_addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r   <= OWN_NONE;
      ram_sel_r <= 1'b0;
      rom_sel_r <= 1'b0;
      lane_r    <= 2'd0;
    end else begin
      owner_r   <= grant;
      ram_sel_r <= ram_sel && (grant != OWN_NONE);
      rom_sel_r <= rom_sel && (grant != OWN_NONE);
      if (grant == OWN_HOST) begin
        lane_r <= bus.host_addr[1:0];
      end
    end
  end

  // Reset masks the response path so an access granted just before reset is never acked.
  always_comb begin
    rd_word = 32'd0;
    if (!rst) begin
      if (ram_sel_r) begin
        rd_word = bus.ram_rddata;
      end else if (rom_sel_r) begin
        rd_word = bus.rom_rddata;
      end
    end
  end

  assign bus.l_rddata    = rd_word;
  assign bus.host_rddata = rd_word[{lane_r, 3'b000} +: 8];
  assign bus.host_ack    = (owner_r == OWN_HOST) && !rst;
  assign bus.l1_ack      = (owner_r == OWN_L1) && !rst;
  assign bus.l2_ack      = (owner_r == OWN_L2) && !rst;
endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: directed steps then random traffic against a cycle-level
// reference model (priority rules, byte-addressed reference RAM, ROM table).
`timescale 1ns/1ps
module tb_membus_arbiter;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  membus_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  membus_arbiter #(.ADDR_WIDTH(AW), .ROM_BASE(6'b10_0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  ram_env [int];
  logic [31:0]  rom_tab [0:1023];
  byte unsigned ref_bytes [int];

  // Environment memories: registered read, RAM chip-selected by addr[17]==0.
  always @(posedge clk) begin
    int          idx;
    logic [31:0] w;
    idx = int'(bus.mem_addr[16:2]);
    w = ram_env.exists(idx) ? ram_env[idx] : 32'h0;
    bus.ram_rddata <= w;
    bus.rom_rddata <= rom_tab[bus.mem_addr[11:2]];
    if (bus.mem_strobe && bus.mem_write && !bus.mem_addr[17]) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_bytesel[b]) w[8*b +: 8] = bus.mem_wrdata[8*b +: 8];
      ram_env[idx] = w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [17:0] a);
    logic [31:0] w;
    int          k;
    w = 32'h0;
    if (!a[17]) begin
      for (int b = 0; b < 4; b++) begin
        k = int'({a[16:2], 2'b00}) + b;
        if (ref_bytes.exists(k)) w[8*b +: 8] = ref_bytes[k];
      end
    end else if (a[17:12] == 6'b10_0000) begin
      w = rom_tab[a[11:2]];
    end
    return w;
  endfunction

  function automatic logic [17:0] rand_addr();
    int         r;
    logic [17:0] off;
    r   = $urandom_range(0, 19);
    off = 18'($urandom_range(0, 63));
    if (r < 12) return off;
    else if (r < 17) return 18'h20000 | off;
    else return 18'h30000 | off;
  endfunction

  // Reference model state: who must be acked this cycle and with what data.
  int          exp_own = 0;          // 0 none, 1 host, 2 L1, 3 L2
  logic [31:0] exp_word = '0;
  logic [1:0]  exp_lane = '0;
  bit          exp_is_write = 1'b0;
  bit          prev_rst = 1'b0;
  bit          rr_l1_next = 1'b1;
  logic        obs_strobe, obs_write;
  logic [3:0]  obs_bytesel;

  task automatic cycle();
    int          w;
    logic [17:0] a;
    @(negedge clk);
    w = 0;
    if (!rst) begin
      if (bus.host_strobe) w = 1;
      else if (bus.l1_strobe && bus.l2_strobe) begin
`ifdef MEMBUS_ROUND_ROBIN_EN
        w = rr_l1_next ? 2 : 3;
`else
        w = 2;
`endif
      end
      else if (bus.l1_strobe) w = 2;
      else if (bus.l2_strobe) w = 3;
    end
    a = (w == 1) ? bus.host_addr : (w == 2) ? bus.l1_addr : (w == 3) ? bus.l2_addr : 18'h0;
    obs_strobe  = bus.mem_strobe;
    obs_write   = bus.mem_write;
    obs_bytesel = bus.mem_bytesel;

    chk("mem_strobe", bus.mem_strobe, (w != 0));
    chk("mem_addr", bus.mem_addr, a);
    chk("mem_write", bus.mem_write, (w == 1) && bus.host_write);
    chk("mem_wrdata", bus.mem_wrdata, rst ? 32'h0 : {4{bus.host_wrdata}});
    if (w != 0 || rst) chk("mem_bytesel", bus.mem_bytesel, rst ? 32'h0 : (32'h1 << a[1:0]));
    chk("host_ack", bus.host_ack, (exp_own == 1) && !rst);
    chk("l1_ack", bus.l1_ack, (exp_own == 2) && !rst);
    chk("l2_ack", bus.l2_ack, (exp_own == 3) && !rst);
    if (rst || prev_rst) begin
      chk("l_rddata_rst", bus.l_rddata, 32'h0);
      chk("host_rddata_rst", bus.host_rddata, 32'h0);
    end else if (exp_own == 1 && !exp_is_write) begin
      chk("host_rddata", bus.host_rddata, exp_word[8*exp_lane +: 8]);
    end else if (exp_own >= 2) begin
      chk("l_rddata", bus.l_rddata, exp_word);
    end

    exp_own      = w;
    exp_word     = ref_read(a);
    exp_lane     = a[1:0];
    exp_is_write = (w == 1) && bus.host_write;
    if (exp_is_write && !a[17]) ref_bytes[int'(a)] = bus.host_wrdata;
    if (rst) rr_l1_next = 1'b1;
    else if (w == 2) rr_l1_next = 1'b0;
    else if (w == 3) rr_l1_next = 1'b1;
    prev_rst = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] tab1 [8];
    logic [2:0] tab2 [8];
    bit         l1_pend, l2_pend;
`ifdef MEMBUS_ROUND_ROBIN_EN
    tab1 = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
    tab2 = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b010};
`else
    tab1 = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    tab2 = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b010, 3'b010, 3'b010};
`endif
    for (int i = 0; i < 1024; i++) rom_tab[i] = $urandom;
    rom_tab[1] = 32'h11223344;

    // Reset held with every strobe high
    rst = 1'b1;
    bus.host_addr = 18'h00013; bus.host_wrdata = 8'h00; bus.host_write = 1'b0;
    bus.host_strobe = 1'b1; bus.l1_strobe = 1'b1; bus.l2_strobe = 1'b1;
    bus.l1_addr = 18'h00040; bus.l2_addr = 18'h00080;
    repeat (3) begin
      chk("rst_acks", {bus.host_ack, bus.l1_ack, bus.l2_ack}, 3'b000);
      cycle();
      chk("rst_mem_strobe", obs_strobe, 1'b0);
    end
    rst = 1'b0;
    cycle();
    chk("first_ack_host", {bus.host_ack, bus.l1_ack, bus.l2_ack}, 3'b100);
    bus.host_strobe = 1'b0; bus.l1_strobe = 1'b0; bus.l2_strobe = 1'b0;

    // Host write 0xA5 to 0x00013, then read it back
    bus.host_wrdata = 8'hA5; bus.host_write = 1'b1; bus.host_strobe = 1'b1;
    cycle();
    chk("wr_bytesel", obs_bytesel, 4'b1000);
    chk("wr_mem_write", obs_write, 1'b1);
    chk("wr_ack", bus.host_ack, 1'b1);
    bus.host_write = 1'b0;
    cycle();
    bus.host_strobe = 1'b0;
    chk("rd_ack", bus.host_ack, 1'b1);
    chk("rd_data", bus.host_rddata, 8'hA5);

    // ROM read, unmapped read, ROM write dropped, RAM word via L2
    bus.l1_addr = 18'h20004; bus.l1_strobe = 1'b1;
    cycle();
    bus.l1_strobe = 1'b0;
    chk("rom_ack", bus.l1_ack, 1'b1);
    chk("rom_data", bus.l_rddata, 32'h11223344);
    bus.l1_addr = 18'h30000; bus.l1_strobe = 1'b1;
    cycle();
    bus.l1_strobe = 1'b0;
    chk("unmapped_ack", bus.l1_ack, 1'b1);
    chk("unmapped_data", bus.l_rddata, 32'h0);
    bus.host_addr = 18'h20008; bus.host_wrdata = 8'h5A; bus.host_write = 1'b1; bus.host_strobe = 1'b1;
    cycle();
    bus.host_strobe = 1'b0; bus.host_write = 1'b0;
    chk("romwr_strobe", obs_strobe, 1'b1);
    chk("romwr_ack", bus.host_ack, 1'b1);
    bus.l2_addr = 18'h20008; bus.l2_strobe = 1'b1;
    cycle();
    chk("romwr_unchanged", bus.l_rddata, rom_tab[2]);
    bus.l2_addr = 18'h00010;
    cycle();
    bus.l2_strobe = 1'b0;
    chk("l2_ram_word", bus.l_rddata, 32'hA500_0000);
    cycle();

    // Contention: both layers for 8 cycles, then again with a host strobe at cycle 4
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.host_addr = 18'h00013;
    for (int k = 0; k < 8; k++) begin
      bus.l1_strobe = 1'b1; bus.l2_strobe = 1'b1;
      cycle();
      chk($sformatf("cont_a%0d", k), {bus.host_ack, bus.l1_ack, bus.l2_ack}, tab1[k]);
    end
    for (int k = 0; k < 8; k++) begin
      bus.host_strobe = (k == 4);
      cycle();
      chk($sformatf("cont_b%0d", k), {bus.host_ack, bus.l1_ack, bus.l2_ack}, tab2[k]);
    end
    bus.host_strobe = 1'b0; bus.l1_strobe = 1'b0; bus.l2_strobe = 1'b0;
    cycle();

    // Reset the cycle after an L2 grant
    bus.l2_addr = 18'h00010; bus.l2_strobe = 1'b1;
    cycle();
    rst = 1'b1; bus.l2_strobe = 1'b0;
    #1;
    chk("midrst_l2_ack", bus.l2_ack, 1'b0);
    chk("midrst_l_rddata", bus.l_rddata, 32'h0);
    cycle();
    rst = 1'b0;
    cycle();

    // Random traffic, layers obey hold-until-ack
    l1_pend = 1'b0; l2_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst             = ($urandom_range(0, 99) == 0);
      bus.host_strobe = ($urandom_range(0, 3) == 0);
      bus.host_write  = 1'($urandom_range(0, 1));
      bus.host_addr   = rand_addr();
      bus.host_wrdata = 8'($urandom);
      if (!l1_pend || bus.l1_ack) begin
        l1_pend = 1'($urandom_range(0, 1));
        bus.l1_strobe = l1_pend;
        if (l1_pend) bus.l1_addr = rand_addr();
      end
      if (!l2_pend || bus.l2_ack) begin
        l2_pend = 1'($urandom_range(0, 1));
        bus.l2_strobe = l2_pend;
        if (l2_pend) bus.l2_addr = rand_addr();
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
